// File: rtl/coproc_pkg.sv
// coproc_pkg: shared mode/state encodings and defaults for the coprocessor instruction path.
package coproc_pkg;
  localparam int INSTR_W_DEFAULT = 22;
  typedef enum logic [1:0] {
    MODE_STEP = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_LOOP = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_HALT
  } state_e;
endpackage

// File: rtl/edge_pulse.sv
// edge_pulse: rising-edge detector against a registered copy of the input.
module edge_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic pulse_o
);
  logic d_q;
  always_ff @(posedge clk) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d_i;
  end
  assign pulse_o = d_i & ~d_q;
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: issues program-buffer entries to the coprocessor in step, run or loop mode.
module instr_sequencer
  import coproc_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEFAULT,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         mode,
  input  logic [ADDR_W:0]    prog_len,
  input  logic               start,
  input  logic               step,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               cop_done,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               finished
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [INSTR_W-1:0]  instr_q;
  logic                valid_q, busy_q, finished_q;
  logic [INSTR_W-1:0]  mem_q [DEPTH];
  logic                start_p, step_p, has_prog, last, run_mode;
  logic [ADDR_W:0]     len;
  logic [ADDR_W-1:0]   pc_nxt, idle_addr;
  mode_e               m;

  edge_pulse u_start (.clk(clk), .rst_n(rst_n), .d_i(start), .pulse_o(start_p));
  edge_pulse u_step  (.clk(clk), .rst_n(rst_n), .d_i(step),  .pulse_o(step_p));

  always_comb begin
    m         = mode_e'(mode);
    len       = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    has_prog  = len != '0;
    last      = {1'b0, pc_q} == len - 1'b1;
    run_mode  = (m == MODE_RUN) || (m == MODE_LOOP);
    pc_nxt    = last ? '0 : pc_q + 1'b1;
    idle_addr = (m == MODE_STEP) ? pc_q : '0;
  end

  // Program memory has no reset so a loaded program survives rst_n.
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < DEPTH_L)) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (has_prog && ((step_p && m == MODE_STEP) || (start_p && run_mode))) begin
            state_q <= ST_ISSUE;
            pc_q    <= idle_addr;
            instr_q <= mem_q[idle_addr];
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (instr_ready) begin
            state_q <= ST_WAIT_DONE;
            valid_q <= 1'b0;
          end else if (m == MODE_HOLD) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        ST_WAIT_DONE: begin
          if (cop_done) begin
            if (last ? (m == MODE_LOOP) : run_mode) begin
              state_q <= ST_ISSUE;
              pc_q    <= pc_nxt;
              instr_q <= mem_q[pc_nxt];
              valid_q <= 1'b1;
            end else if (last && m == MODE_RUN) begin
              state_q    <= ST_HALT;
              busy_q     <= 1'b0;
              finished_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              pc_q    <= (last && m == MODE_HOLD) ? pc_q : pc_nxt;
            end
          end
        end
        ST_HALT: begin
          if (start_p && has_prog) begin
            state_q    <= ST_ISSUE;
            pc_q       <= '0;
            instr_q    <= mem_q[0];
            valid_q    <= 1'b1;
            busy_q     <= 1'b1;
            finished_q <= 1'b0;
          end else if (m == MODE_STEP || m == MODE_HOLD) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            finished_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign finished    = finished_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: scoreboard bench; expected issues come from a program-array model of the sequencing rules.
module tb_instr_sequencer;
  import coproc_pkg::*;
  logic        clk, rst_n, start, step, wr_en, instr_valid, instr_ready, cop_done, busy, finished;
  logic [1:0]  mode;
  logic [4:0]  prog_len;
  logic [3:0]  wr_addr, pc;
  logic [21:0] wr_data, instr;
  typedef struct {logic [21:0] instr; logic [3:0] pc;} exp_t;
  exp_t        sb[$];
  exp_t        m_e;
  logic [21:0] pm [16];
  logic [21:0] m_held, old_val;
  bit          m_stall = 0;
  bit          auto_en = 0;
  int          force_stall = -1;
  int          st;
  int          checks = 0, errors = 0;

  instr_sequencer dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .prog_len(prog_len), .start(start), .step(step),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .cop_done(cop_done), .pc(pc), .busy(busy), .finished(finished)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Coprocessor model: random accept latency, then a done pulse a few cycles later.
  initial forever begin
    @(negedge clk);
    if (auto_en && instr_valid && !instr_ready) begin
      st = force_stall >= 0 ? force_stall : int'($urandom_range(0, 3));
      force_stall = -1;
      repeat (st) @(negedge clk);
      instr_ready = 1;
      @(negedge clk);
      instr_ready = 0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      cop_done = 1;
      @(negedge clk);
      cop_done = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    #2;
    if (m_stall && rst_n) begin
      chk("stall_valid", instr_valid, 1);
      chk("stall_instr", instr, m_held);
    end
    if (instr_valid && instr_ready) begin
      if (sb.size() == 0) chk("unexpected_issue", instr_valid, 0);
      else begin
        m_e = sb.pop_front();
        chk("issue_instr", instr, m_e.instr);
        chk("issue_pc", pc, m_e.pc);
      end
    end
    m_stall = instr_valid && !instr_ready && rst_n;
    m_held  = instr;
  end

  task automatic wr(input logic [3:0] a, input logic [21:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 0;
    pm[a] = d;
  endtask

  task automatic push_seq(input int first, input int n, input int len);
    for (int k = 0; k < n; k++) sb.push_back('{pm[(first + k) % len], 4'((first + k) % len)});
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    repeat (2) @(negedge clk);
    while ((busy || instr_valid) && n < 300) begin @(negedge clk); n++; end
    chk(nm, {30'd0, busy, instr_valid}, 0);
  endtask

  task automatic wait_finished(input string nm);
    int n = 0;
    while (!finished && n < 300) begin @(negedge clk); n++; end
    chk(nm, finished, 1);
  endtask

  task automatic wait_in_wait(input string nm);
    int n = 0;
    while (!(sb.size() == 0 && !instr_valid && busy) && n < 400) begin @(negedge clk); n++; end
    chk(nm, {30'd0, busy, instr_valid}, 2'b10);
  endtask

  task automatic do_step(input string nm);
    step = 1;
    @(negedge clk);
    chk(nm, instr_valid, 1);
    step = 0;
    wait_idle({nm, "_idle"});
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  initial begin
    rst_n = 0; mode = MODE_STEP; prog_len = 0; start = 0; step = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0; instr_ready = 0; cop_done = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid", instr_valid, 0);
    chk("rst_pc", pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_finished", finished, 0);
    chk("rst_instr", instr, 0);
    rst_n = 1;
    for (int i = 0; i < 16; i++) wr(4'(i), i < 3 ? 22'(3 + i) : 22'($urandom));

    auto_en = 1; mode = MODE_STEP; prog_len = 3;
    for (int k = 0; k < 4; k++) begin
      push_seq(k, 1, 3);
      do_step("step_issue");
      if (k == 2) chk("step_wrap_pc", pc, 0);
    end

    mode = MODE_RUN; force_stall = 5;
    push_seq(0, 3, 3);
    pulse_start();
    wait_finished("run_finished");
    @(negedge clk);
    chk("run_busy", busy, 0);
    chk("run_halt_pc", pc, 2);
    mode = MODE_STEP;
    repeat (2) @(negedge clk);
    chk("halt_exit_finished", finished, 0);
    chk("halt_exit_pc", pc, 0);

    mode = MODE_LOOP; prog_len = 2;
    push_seq(0, 5, 2);
    pulse_start();
    wait_in_wait("loop_in_wait");
    mode = MODE_HOLD;
    wait_idle("loop_hold_idle");
    chk("loop_hold_pc", pc, 1);

    mode = MODE_RUN; prog_len = 20;
    push_seq(0, 16, 16);
    pulse_start();
    wait_finished("long_finished");
    chk("long_pc", pc, 15);
    mode = MODE_LOOP;
    push_seq(0, 17, 16);
    pulse_start();
    wait_in_wait("long_loop_wait");
    mode = MODE_HOLD;
    wait_idle("long_hold_idle");
    chk("long_wrap_pc", pc, 1);

    prog_len = 0; mode = MODE_STEP;
    step = 1; @(negedge clk); step = 0;
    mode = MODE_RUN;
    start = 1; @(negedge clk); start = 0;
    repeat (4) @(negedge clk);
    chk("empty_valid", instr_valid, 0);
    chk("empty_busy", busy, 0);

    auto_en = 0; prog_len = 3; mode = MODE_STEP;
    push_seq(1, 1, 3);
    step = 1; @(negedge clk);
    chk("manual_valid", instr_valid, 1);
    instr_ready = 1; @(negedge clk);
    instr_ready = 0; step = 0; @(negedge clk);
    chk("manual_in_wait", {30'd0, busy, instr_valid}, 2'b10);
    step = 1; @(negedge clk);
    cop_done = 1; @(negedge clk);
    cop_done = 0;
    repeat (3) @(negedge clk);
    chk("drop_valid", instr_valid, 0);
    chk("drop_busy", busy, 0);
    chk("drop_pc", pc, 2);

    step = 0; @(negedge clk);
    step = 1; @(negedge clk);
    chk("rst_issue_valid", instr_valid, 1);
    chk("rst_issue_instr", instr, pm[2]);
    rst_n = 0; step = 0; @(negedge clk);
    chk("midrst_valid", instr_valid, 0);
    chk("midrst_pc", pc, 0);
    chk("midrst_instr", instr, 0);
    chk("midrst_busy", busy, 0);
    rst_n = 1;

    prog_len = 1;
    push_seq(0, 1, 1);
    step = 1; @(negedge clk);
    step = 0;
    chk("present_valid", instr_valid, 1);
    old_val = pm[0];
    wr(0, 22'($urandom) ^ old_val ^ 22'h1);
    @(negedge clk);
    chk("present_held", instr, old_val);
    instr_ready = 1; @(negedge clk);
    instr_ready = 0;
    cop_done = 1; @(negedge clk);
    cop_done = 0;
    @(negedge clk);
    chk("present_pc", pc, 0);
    auto_en = 1;
    push_seq(0, 1, 1);
    do_step("new_value_issue");

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
